ysyx_24100006_div: RTL

YSYX_24100006_DIV -- requirements
Module: ysyx_24100006_div

---
 rtl/ysyx_24100006_div_pkg.sv | 27 ++
 rtl/ysyx_24100006_div_step.sv | 28 ++
 rtl/ysyx_24100006_div.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ysyx_24100006_div_pkg.sv
// Shared definitions for the iterative divider and the ID-stage decoder.
//   div_op_e : div_op encodings (DIV, DIVU, REM, REMU)
//   state_e  : divider control states
//   cond_neg : two's-complement negate when asked (used for |x| and sign fix-up)
package ysyx_24100006_div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITERS = 32;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ysyx_24100006_div_step.sv
// One restoring shift-subtract iteration (pure combinational).
//   rem      : 33-bit partial remainder
//   quo      : dividend bits still to shift in (MSB first), quotient bits fill LSB
//   dsr      : divisor magnitude
//   rem_next : partial remainder after trial subtract / restore
//   quo_next : quo shifted left with the new quotient bit in bit 0
module ysyx_24100006_div_step (
  input  logic [32:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] dsr,
  output logic [32:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        borrow;
  logic        fits;

  assign shifted        = {rem[31:0], quo[31]};
  assign {borrow, diff} = {1'b0, shifted} - {2'b00, dsr};
  // A set rem[32] would make the shifted value exceed any divisor, so the
  // subtract always succeeds then; it stays 0 while rem < dsr holds.
  assign fits     = rem[32] | ~borrow;
  assign rem_next = fits ? diff : shifted;
  assign quo_next = {quo[30:0], fits};

endmodule

// File: rtl/ysyx_24100006_div.sv
// 32-bit iterative divider: DIV/DIVU/REM/REMU, valid/ready handshake on both
// sides. Divide-by-zero and signed overflow finish in one cycle; everything
// else takes 32 restoring iterations on operand magnitudes plus sign fix-up.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   in_valid / in_ready    : request handshake (in_ready only in IDLE)
//   dividend, divisor      : operands, sampled on accept
//   div_op                 : div_op_e encoding, sampled on accept
//   out_valid / out_ready  : result handshake (out_valid registered)
//   result                 : quotient or remainder
//   flush                  : abort in-flight op, only with YSYX_24100006_DIV_FLUSH_EN
module ysyx_24100006_div
  import ysyx_24100006_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
`ifdef YSYX_24100006_DIV_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic [1:0]  div_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  logic abort;
`ifdef YSYX_24100006_DIV_FLUSH_EN
  assign abort = flush;
`else
  assign abort = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [32:0] rem_q;
  logic [31:0] quo_q, dsr_q, result_q;
  logic [4:0]  cnt_q;
  logic        neg_q, neg_r, rem_sel, out_valid_q;

  logic        accept, op_signed, op_rem, div0, ovf, special;
  logic [31:0] spec_res, fin_res;
  logic [32:0] step_rem;
  logic [31:0] step_quo;

  assign in_ready  = (state_q == S_IDLE);
  assign accept    = in_valid & in_ready;
  assign op_signed = (div_op == OP_DIV) || (div_op == OP_REM);
  assign op_rem    = (div_op == OP_REM) || (div_op == OP_REMU);
  assign div0      = (divisor == 32'd0);
  assign ovf       = op_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
  assign special   = div0 | ovf;

  always_comb begin
    spec_res = '0;
    if (div0)        spec_res = op_rem ? dividend : 32'hFFFF_FFFF;
    else if (!op_rem) spec_res = 32'h8000_0000;
  end

  ysyx_24100006_div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dsr      (dsr_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Fix-up uses the final iteration's outputs so the result lands on the 32nd edge.
  assign fin_res = rem_sel ? cond_neg(step_rem[31:0], neg_r) : cond_neg(step_quo, neg_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC:  if (cnt_q == 5'd31) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      rem_sel     <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (abort) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (accept) begin
          cnt_q   <= '0;
          rem_sel <= op_rem;
          if (special) begin
            result_q    <= spec_res;
            out_valid_q <= 1'b1;
          end else begin
            rem_q <= '0;
            quo_q <= cond_neg(dividend, op_signed & dividend[31]);
            dsr_q <= cond_neg(divisor, op_signed & divisor[31]);
            neg_q <= op_signed & (dividend[31] ^ divisor[31]);
            neg_r <= op_signed & dividend[31];
          end
        end
        S_CALC: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_q    <= fin_res;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: if (out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
